seq_divider: RTL

Multi-cycle unsigned integer divider built on the library's register and adder/subtracter primitives. It performs restoring division, one quotient bit per clock, and reports completion through a start/done handshake. It is the inverse of the shift-and-add multiply path and serves datapaths that need a quotient and remainder without a wide combinational divider.

---
 rtl/seq_divider.sv | 104 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Quotient, remainder and div_by_zero update only on the completion edge and hold otherwise.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_prem;
  logic [CW-1:0]    r_cnt;
  logic             r_zero;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_prem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_prem_nx;
  logic [WIDTH-1:0] w_shift_nx;

  // The partial remainder is always below the divisor, so WIDTH bits of storage
  // suffice; only the shifted value and the trial need the extra borrow bit.
  always_comb begin
    w_prem_sh  = {r_prem, r_shift[WIDTH-1]};
    w_trial    = w_prem_sh - {1'b0, r_div};
    w_borrow   = w_trial[WIDTH];
    w_prem_nx  = w_borrow ? w_prem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_shift_nx = {r_shift[WIDTH-2:0], ~w_borrow};
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_div   <= '0;
      r_prem  <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // A zero divisor spends a single RUN cycle so results land one edge after start.
            r_shift <= dividend;
            r_div   <= divisor;
            r_prem  <= '0;
            r_zero  <= (divisor == '0);
            r_cnt   <= (divisor == '0) ? CW'(1) : CW'(WIDTH);
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_shift <= w_shift_nx;
          r_prem  <= w_prem_nx;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (r_zero) begin
              r_quot <= '1;
              r_rem  <= r_shift;
              r_dbz  <= 1'b1;
            end else begin
              r_quot <= w_shift_nx;
              r_rem  <= w_prem_nx;
              r_dbz  <= 1'b0;
            end
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
